// File: rtl/ifid_skid_stage_if.sv
// IF/ID handshake bundle: fetch-side input beat, decode-side output beat and decoded fields.
// master = fetch/decode environment, slave = the pipeline stage.
interface ifid_skid_stage_if #(
    parameter int unsigned IR_W = 32,
    parameter int unsigned PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [IR_W-1:0] in_ir;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [IR_W-1:0] out_ir;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_rs;
    logic [4:0]      out_rt;
    logic [4:0]      out_rd;
    logic [4:0]      out_shamt;
    logic [15:0]     out_imm;
    logic [1:0]      occupancy;

    modport master (
        output in_valid, in_ir, in_pc, out_ready,
        input  in_ready, out_valid, out_ir, out_pc,
               out_rs, out_rt, out_rd, out_shamt, out_imm, occupancy
    );

    modport slave (
        input  in_valid, in_ir, in_pc, out_ready,
        output in_ready, out_valid, out_ir, out_pc,
               out_rs, out_rt, out_rd, out_shamt, out_imm, occupancy
    );
endinterface

// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage with a 2-entry skid buffer; in_ready is a flop so a decode stall
// never forms a combinational path back to fetch. flush inserts a bubble.
module ifid_skid_stage #(
    parameter int unsigned IR_W        = 32,
    parameter int unsigned PC_W        = 32,
    parameter bit          BUBBLE_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    ifid_skid_stage_if.slave      bus
);
    localparam int unsigned REG_W = 5;
    localparam int unsigned IMM_W = 16;
    localparam int unsigned FLD_W = 26;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [1:0]      occ_q, occ_d;
    logic [IR_W-1:0] main_ir_q, main_ir_d, skid_ir_q, skid_ir_d;
    logic [PC_W-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [REG_W-1:0] rs_q, rt_q, rd_q, shamt_q;
    logic [IMM_W-1:0] imm_q;
    logic [FLD_W-1:0] fld_d;
    logic             in_fire, out_fire;

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    // Fields track whatever is loaded into the main register, so they reload exactly with it.
    if (IR_W >= FLD_W) begin : g_fld_slice
        assign fld_d = main_ir_d[FLD_W-1:0];
    end else begin : g_fld_pad
        assign fld_d = FLD_W'(main_ir_d);
    end

    always_comb begin
        state_d   = state_q;
        main_ir_d = main_ir_q;
        main_pc_d = main_pc_q;
        skid_ir_d = skid_ir_q;
        skid_pc_d = skid_pc_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d   = ONE;
                    main_ir_d = bus.in_ir;
                    main_pc_d = bus.in_pc;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_ir_d = bus.in_ir;
                    main_pc_d = bus.in_pc;
                end else if (in_fire) begin
                    state_d   = TWO;
                    skid_ir_d = bus.in_ir;
                    skid_pc_d = bus.in_pc;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d   = ONE;
                    main_ir_d = skid_ir_q;
                    main_pc_d = skid_pc_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Redirect discards both held beats and anything handshaking this cycle.
        if (flush) begin
            state_d = EMPTY;
            if (BUBBLE_ZERO) begin
                main_ir_d = '0;
                main_pc_d = '0;
                skid_ir_d = '0;
                skid_pc_d = '0;
            end
        end
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
        occ_d       = 2'(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
            main_ir_q   <= '0;
            main_pc_q   <= '0;
            skid_ir_q   <= '0;
            skid_pc_q   <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            shamt_q     <= '0;
            imm_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
            main_ir_q   <= main_ir_d;
            main_pc_q   <= main_pc_d;
            skid_ir_q   <= skid_ir_d;
            skid_pc_q   <= skid_pc_d;
            rs_q        <= fld_d[25:21];
            rt_q        <= fld_d[20:16];
            rd_q        <= fld_d[15:11];
            shamt_q     <= fld_d[10:6];
            imm_q       <= fld_d[15:0];
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ir    = main_ir_q;
    assign bus.out_pc    = main_pc_q;
    assign bus.out_rs    = rs_q;
    assign bus.out_rt    = rt_q;
    assign bus.out_rd    = rd_q;
    assign bus.out_shamt = shamt_q;
    assign bus.out_imm   = imm_q;
    assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_ifid_skid_stage.sv
// Directed bench for ifid_skid_stage: reset, streaming, skid stall, flush, simultaneous fire, reset in TWO.
module tb_ifid_skid_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;

    ifid_skid_stage_if #(.IR_W(32), .PC_W(32)) bus ();

    ifid_skid_stage #(.IR_W(32), .PC_W(32), .BUBBLE_ZERO(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        bus.in_ir = 32'hDEADBEEF; bus.in_pc = 32'h100;
        rst = 1'b1;
        step(); step();
        rst = 1'b0; bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid: got %0h want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready: got %0h want 1", bus.in_ready); end
        n_cmp++; if (bus.occupancy !== 2'd0) begin n_mis++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy); end
        n_cmp++; if (bus.out_ir !== 32'h0) begin n_mis++; $display("FAIL reset_out_ir: got %0h want 0", bus.out_ir); end
        n_cmp++; if (bus.out_pc !== 32'h0) begin n_mis++; $display("FAIL reset_out_pc: got %0h want 0", bus.out_pc); end
    endtask

    task automatic test_streaming();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_pc = 32'(4 * i);
            bus.in_ir = 32'h2000_0000 + 32'(i);
            step();
            n_cmp++; if (bus.out_pc !== 32'(4 * i)) begin n_mis++; $display("FAIL stream_pc%0d: got %0h want %0h", i, bus.out_pc, 4 * i); end
            n_cmp++; if (bus.occupancy !== 2'd1) begin n_mis++; $display("FAIL stream_occ%0d: got %0d want 1", i, bus.occupancy); end
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL stream_in_ready%0d: got %0h want 1", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL stream_drain_valid: got %0h want 0", bus.out_valid); end
        n_cmp++; if (bus.occupancy !== 2'd0) begin n_mis++; $display("FAIL stream_drain_occ: got %0d want 0", bus.occupancy); end
    endtask

    task automatic test_stall_skid();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_ir = 32'h8C010004; bus.in_pc = 32'h10;
        step();
        bus.in_ir = 32'h00221820; bus.in_pc = 32'h14;
        step();
        // lw $1,4($0): rs=0 rt=1 rd=0 shamt=0 imm=4
        n_cmp++; if (bus.occupancy !== 2'd2) begin n_mis++; $display("FAIL skid_occ: got %0d want 2", bus.occupancy); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_mis++; $display("FAIL skid_in_ready: got %0h want 0", bus.in_ready); end
        n_cmp++; if (bus.out_pc !== 32'h10) begin n_mis++; $display("FAIL skid_pc_first: got %0h want 10", bus.out_pc); end
        n_cmp++; if (bus.out_rs !== 5'd0) begin n_mis++; $display("FAIL skid_rs: got %0d want 0", bus.out_rs); end
        n_cmp++; if (bus.out_rt !== 5'd1) begin n_mis++; $display("FAIL skid_rt: got %0d want 1", bus.out_rt); end
        n_cmp++; if (bus.out_imm !== 16'h0004) begin n_mis++; $display("FAIL skid_imm: got %0h want 4", bus.out_imm); end
        // Offered beat while full must be ignored and the head must hold.
        bus.in_ir = 32'hFFFF_FFFF; bus.in_pc = 32'h18;
        step();
        n_cmp++; if (bus.out_ir !== 32'h8C010004) begin n_mis++; $display("FAIL skid_hold_ir: got %0h want 8c010004", bus.out_ir); end
        n_cmp++; if (bus.occupancy !== 2'd2) begin n_mis++; $display("FAIL skid_hold_occ: got %0d want 2", bus.occupancy); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        step();
        // add $3,$1,$2: rs=1 rt=2 rd=3 shamt=0 imm=1820
        n_cmp++; if (bus.out_pc !== 32'h14) begin n_mis++; $display("FAIL skid_pc_second: got %0h want 14", bus.out_pc); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL skid_in_ready_back: got %0h want 1", bus.in_ready); end
        n_cmp++; if (bus.occupancy !== 2'd1) begin n_mis++; $display("FAIL skid_occ_one: got %0d want 1", bus.occupancy); end
        n_cmp++; if (bus.out_rs !== 5'd1) begin n_mis++; $display("FAIL skid_rs2: got %0d want 1", bus.out_rs); end
        n_cmp++; if (bus.out_rt !== 5'd2) begin n_mis++; $display("FAIL skid_rt2: got %0d want 2", bus.out_rt); end
        n_cmp++; if (bus.out_rd !== 5'd3) begin n_mis++; $display("FAIL skid_rd2: got %0d want 3", bus.out_rd); end
        n_cmp++; if (bus.out_imm !== 16'h1820) begin n_mis++; $display("FAIL skid_imm2: got %0h want 1820", bus.out_imm); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL skid_drain_valid: got %0h want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.in_ir = 32'h11111111; bus.in_pc = 32'h20;
        step();
        bus.in_ir = 32'h22222222; bus.in_pc = 32'h24;
        step();
        n_cmp++; if (bus.occupancy !== 2'd2) begin n_mis++; $display("FAIL flush_pre_occ: got %0d want 2", bus.occupancy); end
        flush = 1'b1; bus.out_ready = 1'b1;
        bus.in_ir = 32'h33333333; bus.in_pc = 32'h28;
        step();
        flush = 1'b0; bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL flush_out_valid: got %0h want 0", bus.out_valid); end
        n_cmp++; if (bus.occupancy !== 2'd0) begin n_mis++; $display("FAIL flush_occ: got %0d want 0", bus.occupancy); end
        n_cmp++; if (bus.out_ir !== 32'h0) begin n_mis++; $display("FAIL flush_out_ir: got %0h want 0", bus.out_ir); end
        n_cmp++; if (bus.out_pc !== 32'h0) begin n_mis++; $display("FAIL flush_out_pc: got %0h want 0", bus.out_pc); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL flush_in_ready: got %0h want 1", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL flush_ghost%0d: got valid %0h pc %0h want 0", i, bus.out_valid, bus.out_pc); end
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        bus.in_ir = 32'h44444444; bus.in_pc = 32'h30;
        step();
        bus.in_ir = 32'h55555555; bus.in_pc = 32'h34;
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.occupancy !== 2'd1) begin n_mis++; $display("FAIL b2b_occ: got %0d want 1", bus.occupancy); end
        n_cmp++; if (bus.out_pc !== 32'h34) begin n_mis++; $display("FAIL b2b_pc: got %0h want 34", bus.out_pc); end
        n_cmp++; if (bus.out_ir !== 32'h55555555) begin n_mis++; $display("FAIL b2b_ir: got %0h want 55555555", bus.out_ir); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL b2b_drain: got %0h want 0", bus.out_valid); end
    endtask

    task automatic test_reset_in_two();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.in_ir = 32'h66666666; bus.in_pc = 32'h40;
        step();
        bus.in_ir = 32'h77777777; bus.in_pc = 32'h44;
        step();
        rst = 1'b1; flush = 1'b1; bus.out_ready = 1'b1;
        bus.in_ir = 32'h88888888; bus.in_pc = 32'h48;
        step();
        rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL rst2_out_valid: got %0h want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL rst2_in_ready: got %0h want 1", bus.in_ready); end
        n_cmp++; if (bus.occupancy !== 2'd0) begin n_mis++; $display("FAIL rst2_occ: got %0d want 0", bus.occupancy); end
        n_cmp++; if (bus.out_pc !== 32'h0) begin n_mis++; $display("FAIL rst2_out_pc: got %0h want 0", bus.out_pc); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL rst2_ghost%0d: got valid %0h pc %0h want 0", i, bus.out_valid, bus.out_pc); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_ir = '0; bus.in_pc = '0;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_back_to_back();
        test_reset_in_two();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
